// File: rtl/bus_sched_pkg.sv
// Shared types and default widths for the round-robin bus scheduler.
package bus_sched_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP
    } state_e;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] wdata;
        logic                      we;
    } cmd_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at N.
module rr_priority_pick #(
    parameter int  N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);

    always_comb begin
        // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
        winner  = '0;
        any_req = 1'b0;
        // Walk offsets from far to near so the closest request to ptr is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                winner  = W'((int'(ptr) + i) % N);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_bus_scheduler.sv
// Round-robin scheduler sharing one slave command/response port among N_MASTERS requesters.
// Define BUS_TIMEOUT_EN to add a watchdog that aborts a transaction after TIMEOUT_CYCLES.
module rr_bus_scheduler
    import bus_sched_pkg::*;
#(
    parameter int  N_MASTERS      = 4,
    parameter int  ADDR_W         = DEFAULT_ADDR_W,
    parameter int  DATA_W         = DEFAULT_DATA_W,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int OWNER_W        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_MASTERS-1:0]        m_req,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [N_MASTERS-1:0]        m_we,
    output logic [N_MASTERS-1:0]        m_gnt,
    output logic [N_MASTERS-1:0]        m_done,
    output logic [DATA_W-1:0]           m_rdata,
    output logic                        s_valid,
    input  logic                        s_ready,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    output logic                        s_we,
    input  logic                        s_resp_valid,
    input  logic [DATA_W-1:0]           s_rdata,
    output logic                        busy,
    output logic [OWNER_W-1:0]          owner
`ifdef BUS_TIMEOUT_EN
    ,
    output logic                        timeout_err
`endif
);

    // The captured command uses the package struct, so its widths must match.
    if (ADDR_W != DEFAULT_ADDR_W || DATA_W != DEFAULT_DATA_W) begin : g_bad_width
        $error("rr_bus_scheduler: ADDR_W/DATA_W must match bus_sched_pkg defaults");
    end
    if (N_MASTERS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("rr_bus_scheduler: N_MASTERS and TIMEOUT_CYCLES must be >= 1");
    end

    state_e                 state_q;
    cmd_t                   cmd_q;
    logic [N_MASTERS-1:0]   gnt_q;
    logic [N_MASTERS-1:0]   done_q;
    logic [DATA_W-1:0]      rdata_q;
    logic                   s_valid_q;
    logic                   busy_q;
    logic [OWNER_W-1:0]     owner_q;
    logic [OWNER_W-1:0]     ptr_q;
    logic [OWNER_W-1:0]     ptr_d;
    logic [OWNER_W-1:0]     pick_idx;
    logic                   pick_any;

    rr_priority_pick #(
        .N(N_MASTERS)
    ) u_pick (
        .req     (m_req),
        .ptr     (ptr_q),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    // Pointer lands one past the finishing owner; with one master it stays at 0.
    assign ptr_d = (owner_q == OWNER_W'(N_MASTERS - 1)) ? '0 : owner_q + OWNER_W'(1);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             timeout_err_q;
    logic             wd_expire;

    // A response arriving on the expiry edge still completes normally.
    assign wd_expire = (state_q != IDLE)
                    && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
                    && !(state_q == RESP && s_resp_valid);
    assign timeout_err = timeout_err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            s_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            ptr_q     <= '0;
`ifdef BUS_TIMEOUT_EN
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            done_q  <= '0;
            rdata_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        cmd_q.addr  <= m_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        cmd_q.wdata <= m_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        cmd_q.we    <= m_we[pick_idx];
                        gnt_q       <= N_MASTERS'(1) << pick_idx;
                        owner_q     <= pick_idx;
                        s_valid_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= CMD;
                    end
                end
                CMD: begin
                    if (s_ready) begin
                        s_valid_q <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (s_resp_valid) begin
                        done_q  <= gnt_q;
                        rdata_q <= cmd_q.we ? '0 : s_rdata;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef BUS_TIMEOUT_EN
            timeout_err_q <= 1'b0;
            wd_cnt_q      <= (state_q == IDLE) ? '0 : wd_cnt_q + CNT_W'(1);
            // Later assignments override the case above when the watchdog fires.
            if (wd_expire) begin
                done_q        <= gnt_q;
                rdata_q       <= '1;
                timeout_err_q <= 1'b1;
                s_valid_q     <= 1'b0;
                gnt_q         <= '0;
                busy_q        <= 1'b0;
                ptr_q         <= ptr_d;
                state_q       <= IDLE;
            end
`endif
        end
    end

    assign m_gnt   = gnt_q;
    assign m_done  = done_q;
    assign m_rdata = rdata_q;
    assign s_valid = s_valid_q;
    assign s_addr  = cmd_q.addr;
    assign s_wdata = cmd_q.wdata;
    assign s_we    = cmd_q.we;
    assign busy    = busy_q;
    assign owner   = owner_q;

endmodule
